// File: rtl/wr_burst_arbiter.sv
// Round-robin arbiter sharing one write-burst engine between NCH FIFO channels.
// Optional macro WR_ARB_TAIL_PRIO_EN gives tail requests strict priority over bursts.
module wr_burst_arbiter #(
    parameter int NCH   = 2,
    parameter int LSIZE = 9,
    parameter int CHW   = 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [NCH-1:0]       ch_burst_req,
    input  logic [NCH-1:0]       ch_tail_req,
    input  logic [NCH*LSIZE-1:0] ch_req_len,
    output logic [NCH-1:0]       ch_resp,
    output logic [NCH-1:0]       ch_done,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [LSIZE-1:0]     cmd_len,
    output logic                 cmd_tail,
    output logic [CHW-1:0]       cmd_ch,
    input  logic                 eng_done,
    output logic                 busy,
    output logic [2:0]           dbg_state,
    output logic [CHW-1:0]       dbg_rr_ptr
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_valid, once raised, stays high with cmd_len/cmd_tail/cmd_ch stable until that edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        BUSY    = 3'd2,
        ZERO    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [CHW-1:0]   rr_ptr, rr_ptr_d;
    logic [NCH-1:0]   req_mask;
    logic             win_found;
    logic [CHW-1:0]   win_idx;
    logic [CHW-1:0]   cand;
    int               idx;
    logic [LSIZE-1:0] win_len;
    logic             win_tail;
    logic [NCH-1:0]   grant_oh;
    logic [LSIZE-1:0] len_arr [NCH];

    logic             cmd_valid_d;
    logic [LSIZE-1:0] cmd_len_d;
    logic             cmd_tail_d;
    logic [CHW-1:0]   cmd_ch_d;
    logic [NCH-1:0]   ch_resp_d;
    logic [NCH-1:0]   ch_done_d;
    logic             busy_d;

    for (genvar g = 0; g < NCH; g++) begin : g_len
        assign len_arr[g] = ch_req_len[g*LSIZE +: LSIZE];
    end

    // Round-robin search starting at rr_ptr over the eligible requester set.
    always_comb begin
`ifdef WR_ARB_TAIL_PRIO_EN
        req_mask = (|ch_tail_req) ? ch_tail_req : ch_burst_req;
`else
        req_mask = ch_burst_req | ch_tail_req;
`endif
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        idx       = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            cand = CHW'(idx);
            if (!win_found && req_mask[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_len    = len_arr[win_idx];
    assign win_tail   = ch_tail_req[win_idx];
    assign grant_oh   = NCH'(1) << cmd_ch;
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cmd_valid <= 1'b0;
            cmd_len   <= '0;
            cmd_tail  <= 1'b0;
            cmd_ch    <= '0;
            ch_resp   <= '0;
            ch_done   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            cmd_valid <= cmd_valid_d;
            cmd_len   <= cmd_len_d;
            cmd_tail  <= cmd_tail_d;
            cmd_ch    <= cmd_ch_d;
            ch_resp   <= ch_resp_d;
            ch_done   <= ch_done_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d  = state;
        rr_ptr_d = rr_ptr;
        case (state)
            IDLE:    if (win_found) state_d = (win_len == '0) ? ZERO : ISSUE;
            ISSUE:   if (cmd_valid && cmd_ready) state_d = BUSY;
            BUSY:    if (eng_done) state_d = RELEASE;
            ZERO:    state_d = RELEASE;
            RELEASE: begin
                state_d  = IDLE;
                rr_ptr_d = (int'(cmd_ch) == NCH - 1) ? '0 : cmd_ch + CHW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are computed from the transition being taken this cycle.
    always_comb begin
        cmd_valid_d = 1'b0;
        cmd_len_d   = cmd_len;
        cmd_tail_d  = cmd_tail;
        cmd_ch_d    = cmd_ch;
        ch_resp_d   = '0;
        ch_done_d   = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    cmd_ch_d   = win_idx;
                    cmd_len_d  = win_len;
                    cmd_tail_d = win_tail;
                    if (win_len == '0) ch_resp_d = NCH'(1) << win_idx;
                    else               cmd_valid_d = 1'b1;
                end
            end
            ISSUE: begin
                if (cmd_valid && cmd_ready) ch_resp_d   = grant_oh;
                else                        cmd_valid_d = 1'b1;
            end
            BUSY:    if (eng_done) ch_done_d = grant_oh;
            ZERO:    ch_done_d = grant_oh;
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_wr_burst_arbiter.sv
// Directed self-checking bench for wr_burst_arbiter (NCH=2, LSIZE=9, CHW=1).
module tb_wr_burst_arbiter;
    localparam int NCH   = 2;
    localparam int LSIZE = 9;
    localparam int CHW   = 1;

    logic                 clock;
    logic                 rst;
    logic [NCH-1:0]       ch_burst_req;
    logic [NCH-1:0]       ch_tail_req;
    logic [NCH*LSIZE-1:0] ch_req_len;
    logic [NCH-1:0]       ch_resp;
    logic [NCH-1:0]       ch_done;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LSIZE-1:0]     cmd_len;
    logic                 cmd_tail;
    logic [CHW-1:0]       cmd_ch;
    logic                 eng_done;
    logic                 busy;
    logic [2:0]           dbg_state;
    logic [CHW-1:0]       dbg_rr_ptr;

    int n_vec = 0;
    int n_err = 0;
    logic [CHW-1:0] exp_q[$];

    wr_burst_arbiter #(.NCH(NCH), .LSIZE(LSIZE), .CHW(CHW)) dut (
        .clock(clock), .rst(rst),
        .ch_burst_req(ch_burst_req), .ch_tail_req(ch_tail_req), .ch_req_len(ch_req_len),
        .ch_resp(ch_resp), .ch_done(ch_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_tail(cmd_tail), .cmd_ch(cmd_ch), .eng_done(eng_done), .busy(busy),
        .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_len(input int ch, input int len);
        ch_req_len[ch*LSIZE +: LSIZE] = LSIZE'(len);
    endtask

    task automatic wait_valid(output logic ok);
        int n;
        n = 0;
        while (!cmd_valid && n < 10) begin
            tick();
            n++;
        end
        ok = cmd_valid;
    endtask

    function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] c);
        return NCH'(1) << c;
    endfunction

    initial begin
        logic           ok;
        logic [CHW-1:0] e;
        logic [CHW-1:0] prev;
        rst = 1'b1;
        ch_burst_req = '0;
        ch_tail_req = '0;
        ch_req_len = '0;
        cmd_ready = 1'b0;
        eng_done = 1'b0;
        prev = '0;
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_len",   32'(cmd_len),   32'd0);
        check("rst_tail",  32'(cmd_tail),  32'd0);
        check("rst_ch",    32'(cmd_ch),    32'd0);
        check("rst_resp",  32'(ch_resp),   32'd0);
        check("rst_done",  32'(ch_done),   32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_rr",    32'(dbg_rr_ptr), 32'd0);
        rst = 1'b0;
        tick();

        // Single burst on ch0
        set_len(0, 200);
        ch_burst_req = 2'b01;
        cmd_ready = 1'b1;
        tick();
        check("t1_valid", 32'(cmd_valid), 32'd1);
        check("t1_len",   32'(cmd_len),   32'd200);
        check("t1_ch",    32'(cmd_ch),    32'd0);
        check("t1_tail",  32'(cmd_tail),  32'd0);
        check("t1_busy",  32'(busy),      32'd1);
        check("t1_resp_early", 32'(ch_resp), 32'd0);
        tick();
        check("t1_resp",  32'(ch_resp),   32'h1);
        check("t1_valid_drop", 32'(cmd_valid), 32'd0);
        ch_burst_req = '0;
        repeat (9) begin
            tick();
            check("t1_no_done", 32'(ch_done), 32'd0);
        end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("t1_done",      32'(ch_done), 32'h1);
        check("t1_busy_rel",  32'(busy),    32'd1);
        tick();
        check("t1_done_clr",  32'(ch_done), 32'd0);
        check("t1_busy_low",  32'(busy),    32'd0);
        check("t1_rr",        32'(dbg_rr_ptr), 32'd1);

        // Both channels requesting: grants alternate starting at rr_ptr=1
        set_len(0, 200);
        set_len(1, 200);
        ch_burst_req = 2'b11;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_valid(ok);
            check("t2_timeout", 32'(ok), 32'd1);
            e = exp_q.pop_front();
            check("t2_ch",  32'(cmd_ch),  32'(e));
            check("t2_len", 32'(cmd_len), 32'd200);
            if (i > 0) check("t2_norepeat", 32'(cmd_ch != prev), 32'd1);
            prev = cmd_ch;
            tick();
            check("t2_resp", 32'(ch_resp), 32'(onehot(e)));
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
            check("t2_done", 32'(ch_done), 32'(onehot(e)));
            check("t2_excl", 32'(|(ch_done & ch_resp)), 32'd0);
            if (i == 3) ch_burst_req = '0;
            tick();
        end
        check("t2_rr", 32'(dbg_rr_ptr), 32'd1);

        // ch1 burst+tail: tail wins; latched data stable while ready held low
        set_len(1, 37);
        ch_burst_req = 2'b10;
        ch_tail_req = 2'b10;
        cmd_ready = 1'b0;
        tick();
        check("t3_valid", 32'(cmd_valid), 32'd1);
        check("t3_tail",  32'(cmd_tail),  32'd1);
        check("t3_len",   32'(cmd_len),   32'd37);
        check("t3_ch",    32'(cmd_ch),    32'd1);
        set_len(1, 99);
        ch_burst_req = '0;
        ch_tail_req = '0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
            check("t3_hold_valid", 32'(cmd_valid), 32'd1);
            check("t3_hold_len",   32'(cmd_len),   32'd37);
            check("t3_hold_tail",  32'(cmd_tail),  32'd1);
            check("t3_no_done",    32'(ch_done),   32'd0);
            check("t3_no_resp",    32'(ch_resp),   32'd0);
        end
        cmd_ready = 1'b1;
        tick();
        check("t3_resp",       32'(ch_resp),   32'h2);
        check("t3_valid_drop", 32'(cmd_valid), 32'd0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("t3_done", 32'(ch_done), 32'h2);
        tick();
        check("t3_rr_wrap", 32'(dbg_rr_ptr), 32'd0);
        check("t3_busy",    32'(busy),       32'd0);

        // Zero-length request on ch0
        set_len(0, 0);
        ch_burst_req = 2'b01;
        tick();
        check("t4_resp",  32'(ch_resp),   32'h1);
        check("t4_valid", 32'(cmd_valid), 32'd0);
        check("t4_state", 32'(dbg_state), 32'd3);
        ch_burst_req = '0;
        tick();
        check("t4_done",     32'(ch_done),   32'h1);
        check("t4_resp_clr", 32'(ch_resp),   32'd0);
        check("t4_valid2",   32'(cmd_valid), 32'd0);
        tick();
        check("t4_done_clr", 32'(ch_done),    32'd0);
        check("t4_busy",     32'(busy),       32'd0);
        check("t4_rr",       32'(dbg_rr_ptr), 32'd1);

        // Search wraps past rr_ptr=1 to ch0, then reset in BUSY
        set_len(0, 5);
        ch_burst_req = 2'b01;
        tick();
        check("t5_ch",    32'(cmd_ch),    32'd0);
        check("t5_len",   32'(cmd_len),   32'd5);
        check("t5_valid", 32'(cmd_valid), 32'd1);
        tick();
        check("t5_state_busy", 32'(dbg_state), 32'd2);
        check("t5_resp",       32'(ch_resp),   32'h1);
        rst = 1'b1;
        ch_burst_req = '0;
        tick();
        check("t5_rst_valid", 32'(cmd_valid), 32'd0);
        check("t5_rst_len",   32'(cmd_len),   32'd0);
        check("t5_rst_tail",  32'(cmd_tail),  32'd0);
        check("t5_rst_ch",    32'(cmd_ch),    32'd0);
        check("t5_rst_resp",  32'(ch_resp),   32'd0);
        check("t5_rst_done",  32'(ch_done),   32'd0);
        check("t5_rst_busy",  32'(busy),      32'd0);
        check("t5_rst_state", 32'(dbg_state), 32'd0);
        check("t5_rst_rr",    32'(dbg_rr_ptr), 32'd0);
        rst = 1'b0;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("t5_idle_done", 32'(ch_done), 32'd0);
        tick();
        check("t5_idle_done2", 32'(ch_done), 32'd0);
        check("t5_idle_state", 32'(dbg_state), 32'd0);

        // ch0 burst vs ch1 tail with rr_ptr=0
        set_len(0, 10);
        set_len(1, 20);
        ch_burst_req = 2'b01;
        ch_tail_req = 2'b10;
        tick();
`ifdef WR_ARB_TAIL_PRIO_EN
        check("t6_ch",   32'(cmd_ch),   32'd1);
        check("t6_tail", 32'(cmd_tail), 32'd1);
        check("t6_len",  32'(cmd_len),  32'd20);
`else
        check("t6_ch",   32'(cmd_ch),   32'd0);
        check("t6_tail", 32'(cmd_tail), 32'd0);
        check("t6_len",  32'(cmd_len),  32'd10);
`endif
        check("t6_valid", 32'(cmd_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wr_burst_arbiter.md
Name: wr_burst_arbiter

Overview:
- Shares one AXI write-burst engine between NCH FIFO channels.
- Each channel's FIFO status controller raises a burst or tail request with a length; this block grants one channel at a time and issues a single command to the engine.
- It routes the engine's accept (resp) and completion (done) pulses back to the granted channel only.
- Sits between the per-channel FIFO status controllers and the write-burst engine.

Parameters:
NCH, 2, number of requesting channels (2..8)
LSIZE, 9, burst length field width in beats
CHW, 1, channel index width; must satisfy 2**CHW >= NCH

Ports:
clock  in  1  system clock
rst  in  1  synchronous reset, active-high
ch_burst_req  in  NCH  per-channel full-burst request, level, held until ch_resp
ch_tail_req  in  NCH  per-channel tail request, level, held until ch_resp
ch_req_len  in  NCH*LSIZE  per-channel length; channel i occupies bits [i*LSIZE +: LSIZE]
ch_resp  out  NCH  one-hot 1-cycle pulse: command accepted by engine
ch_done  out  NCH  one-hot 1-cycle pulse: burst completed
cmd_valid  out  1  command valid to engine
cmd_ready  in  1  engine accepts command
cmd_len  out  LSIZE  burst length to engine
cmd_tail  out  1  command is a tail burst
cmd_ch  out  CHW  granted channel index
eng_done  in  1  engine burst-complete pulse
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0. All outputs are 0: cmd_valid, cmd_len, cmd_tail, cmd_ch, ch_resp, ch_done, busy.
- Reset mid-operation aborts the grant silently: no resp/done is emitted and the engine is not notified.
- Channel i is requesting when ch_burst_req[i] | ch_tail_req[i].
- Arbitration is round-robin. Search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... modulo NCH; the first requesting channel wins.
- If the winner has both request bits set, tail wins: cmd_tail=1.
- FSM, all outputs registered:
  - IDLE: if any request, latch grant index, len and tail flag, then go to ISSUE. cmd_valid rises on the cycle after the request is first seen (1-cycle latency).
  - IDLE, zero-length case: if the latched len==0, go to ZERO instead of ISSUE.
  - ISSUE: cmd_valid=1; cmd_len, cmd_tail and cmd_ch are stable.
  - ISSUE, on cmd_valid&cmd_ready: drop cmd_valid next cycle, pulse ch_resp[grant] for 1 cycle (the cycle after the handshake), go to BUSY.
  - BUSY: on eng_done, pulse ch_done[grant] for 1 cycle (the cycle after eng_done), go to RELEASE.
  - ZERO: pulse ch_resp[grant], then ch_done[grant] on the next cycle; no engine command is issued. Then go to RELEASE.
  - RELEASE: rr_ptr <= grant+1, wrapping to 0 when grant==NCH-1. Then go to IDLE.
- Maximum request-to-request turnaround in IDLE: a new grant is possible on the cycle after RELEASE.
- Grant data is latched in IDLE and ignored afterwards. Changes to ch_req_len or the request bits after latching do not alter the command in flight.
- A request dropping before handshake does not cancel the command; it is still issued.
- eng_done seen in ISSUE or IDLE is ignored; it is a protocol error and must not produce ch_done.
- cmd_ready with cmd_valid=0 has no effect.
- Non-granted channels never see resp/done. ch_resp and ch_done are never high together.
- cmd_ch is zero-extended; indices >= NCH are never produced.

Optional Feature:
WR_ARB_TAIL_PRIO_EN
- Defined: tail requests take strict priority. If any ch_tail_req bit is set, round-robin runs over the tail requesters only, starting at rr_ptr; otherwise it runs over burst requesters. This flushes frame tails ahead of bulk traffic.
- Undefined: plain round-robin over all requesters; tail only selects cmd_tail for the winner.

Test Plan:
- Reset, then ch_burst_req=2'b01, len[0]=200, cmd_ready=1 -> cmd_valid 1 cycle after req with cmd_len=200, cmd_ch=0, cmd_tail=0; ch_resp=2'b01 next cycle; eng_done 10 cycles later -> ch_done=2'b01 1 cycle after it; busy low after RELEASE.
- Both channels continuously request with len=200 -> grants alternate ch0, ch1, ch0, ch1; no channel is granted twice consecutively.
- ch1 has burst and tail set, len=37 -> cmd_tail=1, cmd_len=37, cmd_ch=1.
- Zero length on ch0 (len=0) -> cmd_valid never rises; ch_resp[0] then ch_done[0] on consecutive cycles.
- cmd_ready held 0 for 5 cycles -> cmd_valid and cmd_len stable throughout. eng_done pulsed in ISSUE -> no ch_done.
- rst asserted in BUSY -> next cycle all outputs 0 and rr_ptr=0. WR_ARB_TAIL_PRIO_EN with ch0 burst, ch1 tail, rr_ptr=0 -> ch1 granted first.
